// File: rtl/poly_plot_engine.sv
// Per-pixel Horner plotter: p(x), p(x+1) vs y -> curve/axis/tick hits, frame-synchronous pan/zoom/commit.
// Fixed DEG+2 cycle latency, one pixel per cycle; no backpressure (the pixel stream is never stalled).
module poly_plot_engine #(
  parameter int DEG  = 4,
  parameter int CW   = 17,
  parameter int XW   = 12,
  parameter int ACC  = 40,
  parameter int ZMAX = 3,
  parameter int X0   = 400,
  parameter int Y0   = 240,
  parameter int STEP = 10
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_coef_we,
  input  logic [$clog2(DEG+1)-1:0]   i_coef_idx,
  input  logic signed [CW-1:0]       i_coef_data,
  input  logic                       i_coef_commit,
  input  logic                       i_frame_start,
  input  logic                       i_pan_left,
  input  logic                       i_pan_right,
  input  logic                       i_pan_up,
  input  logic                       i_pan_down,
  input  logic                       i_zoom_in,
  input  logic                       i_zoom_out,
  input  logic                       i_pix_valid,
  input  logic [XW-1:0]              i_hpos,
  input  logic [XW-1:0]              i_vpos,
  output logic                       o_out_valid,
  output logic [XW-1:0]              o_out_hpos,
  output logic [XW-1:0]              o_out_vpos,
  output logic                       o_hit_curve,
  output logic                       o_hit_axis,
  output logic                       o_hit_tick,
  output logic                       o_ovf,
  output logic [$clog2(ZMAX+1)-1:0]  o_zoom
);

  localparam int IW  = $clog2(DEG + 1);
  localparam int ZW  = $clog2(ZMAX + 1);
  localparam int SXW = XW + 2;
  localparam int PW  = ACC + SXW + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-ACC+1){1'b0}}, {(ACC-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = -SAT_MAX;
  localparam logic [ZW-1:0]        ZMAX_V  = ZW'(ZMAX);

  typedef struct packed {
    logic                  vld;
    logic [XW-1:0]         hpos;
    logic [XW-1:0]         vpos;
    logic signed [SXW-1:0] x;
    logic signed [SXW-1:0] x1;
    logic signed [SXW-1:0] y;
    logic signed [ACC-1:0] acc_a;
    logic signed [ACC-1:0] acc_b;
    logic                  ovf;
  } stage_t;

  typedef struct packed {
    logic                  ovf;
    logic signed [ACC-1:0] val;
  } mac_t;

  function automatic logic signed [ACC-1:0] sext_coef(input logic signed [CW-1:0] c);
    return {{(ACC-CW){c[CW-1]}}, c};
  endfunction

  // Exact acc*x + c at full width, then clamp to the symmetric accumulator range.
  function automatic mac_t mac_sat(input logic signed [ACC-1:0] acc,
                                   input logic signed [SXW-1:0] x,
                                   input logic signed [CW-1:0]  c);
    logic signed [PW-1:0] ea, ex, ec, s;
    mac_t res;
    ea = {{(PW-ACC){acc[ACC-1]}}, acc};
    ex = {{(PW-SXW){x[SXW-1]}}, x};
    ec = {{(PW-CW){c[CW-1]}}, c};
    s  = ea * ex + ec;
    res.ovf = 1'b0;
    if (s > SAT_MAX) begin
      s = SAT_MAX;
      res.ovf = 1'b1;
    end else if (s < SAT_MIN) begin
      s = SAT_MIN;
      res.ovf = 1'b1;
    end
    res.val = s[ACC-1:0];
    return res;
  endfunction

  logic signed [CW-1:0]  r_shadow [DEG+1];
  logic signed [CW-1:0]  r_active [DEG+1];
  logic                  r_armed;
  logic signed [SXW-1:0] r_shift_x, r_shift_y, r_tgt_x, r_tgt_y;
  logic [ZW-1:0]         r_zoom, r_tgt_zoom;
  stage_t                r_st [DEG+1];

  logic signed [SXW-1:0] w_dpan_x, w_dpan_y, w_dx, w_x0, w_y0;
  logic [ZW-1:0]         w_tgt_zoom_nx;
  stage_t                w_nx [DEG+1];
  mac_t                  w_ma [1:DEG];
  mac_t                  w_mb [1:DEG];

  // Pan/zoom requests build up in target registers; frame_start copies them to the live view.
  always_comb begin
    w_dpan_x      = '0;
    w_dpan_y      = '0;
    w_tgt_zoom_nx = r_tgt_zoom;
    if (i_pan_left && !i_pan_right)      w_dpan_x = SXW'(STEP);
    else if (i_pan_right && !i_pan_left) w_dpan_x = -SXW'(STEP);
    if (i_pan_up && !i_pan_down)         w_dpan_y = SXW'(STEP);
    else if (i_pan_down && !i_pan_up)    w_dpan_y = -SXW'(STEP);
    if (i_zoom_in && !i_zoom_out && r_tgt_zoom != ZMAX_V)
      w_tgt_zoom_nx = r_tgt_zoom + 1'b1;
    else if (i_zoom_out && !i_zoom_in && r_tgt_zoom != '0)
      w_tgt_zoom_nx = r_tgt_zoom - 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i <= DEG; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_armed    <= 1'b0;
      r_shift_x  <= SXW'(X0);
      r_shift_y  <= SXW'(Y0);
      r_tgt_x    <= SXW'(X0);
      r_tgt_y    <= SXW'(Y0);
      r_zoom     <= '0;
      r_tgt_zoom <= '0;
    end else begin
      for (int i = 0; i <= DEG; i++) begin
        if (i_coef_we && i_coef_idx == IW'(i)) r_shadow[i] <= i_coef_data;
        if (i_frame_start && r_armed)          r_active[i] <= r_shadow[i];
      end
      r_armed    <= i_coef_commit | (r_armed & ~i_frame_start);
      r_tgt_x    <= r_tgt_x + w_dpan_x;
      r_tgt_y    <= r_tgt_y + w_dpan_y;
      r_tgt_zoom <= w_tgt_zoom_nx;
      if (i_frame_start) begin
        r_shift_x <= r_tgt_x;
        r_shift_y <= r_tgt_y;
        r_zoom    <= r_tgt_zoom;
      end
    end
  end

  assign w_dx = $signed({{(SXW-XW){1'b0}}, i_hpos}) - r_shift_x;
  assign w_x0 = w_dx >>> r_zoom;
  assign w_y0 = r_shift_y - $signed({{(SXW-XW){1'b0}}, i_vpos});

  // Stage 0 seeds both accumulators with the leading coefficient; stage k folds in a[DEG-k].
  always_comb begin
    w_nx[0]       = '0;
    w_nx[0].vld   = i_pix_valid;
    w_nx[0].hpos  = i_hpos;
    w_nx[0].vpos  = i_vpos;
    w_nx[0].x     = w_x0;
    w_nx[0].x1    = w_x0 + SXW'(1);
    w_nx[0].y     = w_y0;
    w_nx[0].acc_a = sext_coef(r_active[DEG]);
    w_nx[0].acc_b = sext_coef(r_active[DEG]);
    for (int k = 1; k <= DEG; k++) begin
      w_ma[k]       = mac_sat(r_st[k-1].acc_a, r_st[k-1].x,  r_active[DEG-k]);
      w_mb[k]       = mac_sat(r_st[k-1].acc_b, r_st[k-1].x1, r_active[DEG-k]);
      w_nx[k]       = r_st[k-1];
      w_nx[k].acc_a = w_ma[k].val;
      w_nx[k].acc_b = w_mb[k].val;
      w_nx[k].ovf   = r_st[k-1].ovf | w_ma[k].ovf | w_mb[k].ovf;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k <= DEG; k++) r_st[k] <= '0;
    end else begin
      for (int k = 0; k <= DEG; k++) r_st[k] <= w_nx[k];
    end
  end

  logic signed [SXW-1:0] w_lx, w_ly;
  logic signed [ACC-1:0] w_la, w_lb, w_ly_ext;
  logic [SXW-1:0]        w_ax, w_ay;
  logic                  w_curve, w_axis, w_tick;

  assign w_lx     = r_st[DEG].x;
  assign w_ly     = r_st[DEG].y;
  assign w_la     = r_st[DEG].acc_a;
  assign w_lb     = r_st[DEG].acc_b;
  assign w_ly_ext = {{(ACC-SXW){w_ly[SXW-1]}}, w_ly};
  assign w_ax     = w_lx[SXW-1] ? -w_lx : w_lx;
  assign w_ay     = w_ly[SXW-1] ? -w_ly : w_ly;
  assign w_curve  = (w_la <= w_ly_ext && w_ly_ext <= w_lb) ||
                    (w_lb <= w_ly_ext && w_ly_ext <= w_la);
  assign w_axis   = (w_lx == '0) || (w_ly == '0);
  assign w_tick   = (((w_ax % SXW'(10))  == '0) && (w_ay < SXW'(4)))  ||
                    (((w_ax % SXW'(100)) == '0) && (w_ay < SXW'(10))) ||
                    (((w_ay % SXW'(10))  == '0) && (w_ax < SXW'(4)))  ||
                    (((w_ay % SXW'(100)) == '0) && (w_ax < SXW'(10)));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_out_valid <= 1'b0;
      o_out_hpos  <= '0;
      o_out_vpos  <= '0;
      o_hit_curve <= 1'b0;
      o_hit_axis  <= 1'b0;
      o_hit_tick  <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      o_out_valid <= r_st[DEG].vld;
      o_out_hpos  <= r_st[DEG].hpos;
      o_out_vpos  <= r_st[DEG].vpos;
      o_hit_curve <= r_st[DEG].vld & ~r_st[DEG].ovf & w_curve;
      o_hit_axis  <= r_st[DEG].vld & w_axis;
      o_hit_tick  <= r_st[DEG].vld & w_tick;
      o_ovf       <= r_st[DEG].vld & r_st[DEG].ovf;
    end
  end

  assign o_zoom = r_zoom;

endmodule

// File: tb/tb_poly_plot_engine.sv
// Scoreboard bench for poly_plot_engine: expectations come from a plain-arithmetic model at issue time.
module tb_poly_plot_engine;
  localparam int DEG = 4, CW = 17, XW = 12, ACC = 40, ZMAX = 3;
  localparam int X0 = 400, Y0 = 240, STEP = 10, LAT = DEG + 2;
  localparam longint SATV = (64'sd1 <<< (ACC - 1)) - 1;

  logic clk = 1'b0, rst = 1'b0;
  logic we, commit, fs, pl, pr, pu, pd, zi, zo, pv;
  logic [2:0] cidx;
  logic signed [CW-1:0] cdata;
  logic [XW-1:0] hpos, vpos;
  logic ov, hc, ha, ht, hovf;
  logic [XW-1:0] oh, ovp;
  logic [1:0] zm;

  poly_plot_engine dut (
    .i_clk(clk), .i_reset(rst), .i_coef_we(we), .i_coef_idx(cidx), .i_coef_data(cdata),
    .i_coef_commit(commit), .i_frame_start(fs), .i_pan_left(pl), .i_pan_right(pr),
    .i_pan_up(pu), .i_pan_down(pd), .i_zoom_in(zi), .i_zoom_out(zo), .i_pix_valid(pv),
    .i_hpos(hpos), .i_vpos(vpos), .o_out_valid(ov), .o_out_hpos(oh), .o_out_vpos(ovp),
    .o_hit_curve(hc), .o_hit_axis(ha), .o_hit_tick(ht), .o_ovf(hovf), .o_zoom(zm)
  );

  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  typedef struct { int hpos; int vpos; bit curve; bit axis; bit tick; bit ovf; longint issue; } exp_t;
  exp_t sbq[$];

  int m_shadow[DEG+1], m_active[DEG+1];
  bit m_armed;
  int m_sx, m_sy, m_zoom, m_tx, m_ty, m_tz;

  function automatic void model_reset();
    for (int i = 0; i <= DEG; i++) begin m_shadow[i] = 0; m_active[i] = 0; end
    m_armed = 0; m_sx = X0; m_sy = Y0; m_tx = X0; m_ty = Y0; m_zoom = 0; m_tz = 0;
  endfunction

  function automatic int floor_div_pow2(input int d, input int z);
    int p = 1 << z;
    if (d >= 0) return d / p;
    return -((-d + p - 1) / p);
  endfunction

  function automatic void poly(input int x, output longint val, output bit o);
    longint a = m_active[DEG];
    o = 0;
    for (int k = DEG - 1; k >= 0; k--) begin
      a = a * x + m_active[k];
      if (a > SATV) begin a = SATV; o = 1; end
      else if (a < -SATV) begin a = -SATV; o = 1; end
    end
    val = a;
  endfunction

  function automatic exp_t predict(input int h, input int v);
    exp_t e;
    int x, y, ax, ay;
    longint pa, pb;
    bit oa, ob;
    x = floor_div_pow2(h - m_sx, m_zoom);
    y = m_sy - v;
    poly(x, pa, oa);
    poly(x + 1, pb, ob);
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    e.hpos  = h;
    e.vpos  = v;
    e.ovf   = oa | ob;
    e.curve = !e.ovf && ((pa <= y && y <= pb) || (pb <= y && y <= pa));
    e.axis  = (x == 0) || (y == 0);
    e.tick  = (ax % 10 == 0 && ay < 4) || (ax % 100 == 0 && ay < 10) ||
              (ay % 10 == 0 && ax < 4) || (ay % 100 == 0 && ax < 10);
    e.issue = cyc;
    return e;
  endfunction

  task automatic zero_inputs();
    we = 0; commit = 0; fs = 0; pl = 0; pr = 0; pu = 0; pd = 0; zi = 0; zo = 0; pv = 0;
    cidx = '0; cdata = '0; hpos = '0; vpos = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); zero_inputs(); end
  endtask

  task automatic pixel(input int h, input int v);
    @(negedge clk); zero_inputs();
    pv = 1; hpos = XW'(h); vpos = XW'(v);
    sbq.push_back(predict(h, v));
  endtask

  task automatic coef(input int idx, input int d);
    @(negedge clk); zero_inputs();
    we = 1; cidx = 3'(idx); cdata = CW'(d);
    m_shadow[idx] = d;
  endtask

  task automatic do_commit();
    @(negedge clk); zero_inputs();
    commit = 1; m_armed = 1;
  endtask

  task automatic frame();
    @(negedge clk); zero_inputs();
    fs = 1;
    if (m_armed) for (int i = 0; i <= DEG; i++) m_active[i] = m_shadow[i];
    m_armed = 0; m_sx = m_tx; m_sy = m_ty; m_zoom = m_tz;
  endtask

  task automatic pan(input bit l, input bit r, input bit u, input bit d);
    @(negedge clk); zero_inputs();
    pl = l; pr = r; pu = u; pd = d;
    if (l && !r) m_tx += STEP;
    if (r && !l) m_tx -= STEP;
    if (u && !d) m_ty += STEP;
    if (d && !u) m_ty -= STEP;
  endtask

  task automatic zoomp(input bit i, input bit o);
    @(negedge clk); zero_inputs();
    zi = i; zo = o;
    if (i && !o && m_tz < ZMAX) m_tz++;
    else if (o && !i && m_tz > 0) m_tz--;
  endtask

  task automatic check_val(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 20 && sbq.size() != 0; i++) begin
      @(negedge clk); zero_inputs();
    end
    check_val("drain_pending", sbq.size(), 0);
    idle(2);
  endtask

  // Monitor: pops one expectation per valid output, checks idle outputs stay quiet.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      checks++;
      if (ov) begin
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got pixel (%0d,%0d) expected none", oh, ovp);
        end else begin
          e = sbq.pop_front();
          if (int'(oh) != e.hpos || int'(ovp) != e.vpos || hc != e.curve || ha != e.axis ||
              ht != e.tick || hovf != e.ovf || (cyc - e.issue) != LAT) begin
            errors++;
            $display("FAIL pixel (%0d,%0d): got pos=(%0d,%0d) c/a/t/o=%b%b%b%b lat=%0d required c/a/t/o=%b%b%b%b lat=%0d",
                     e.hpos, e.vpos, oh, ovp, hc, ha, ht, hovf, cyc - e.issue,
                     e.curve, e.axis, e.tick, e.ovf, LAT);
          end
        end
      end else if ({hc, ha, ht, hovf} != 4'b0000) begin
        errors++;
        $display("FAIL idle_flags: got %b required 0000", {hc, ha, ht, hovf});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, v, x, rdeg;
    longint pval;
    bit po;
    zero_inputs();
    model_reset();
    #2 rst = 1;
    repeat (3) @(negedge clk);
    check_val("reset_out_valid", ov, 0);
    check_val("reset_flags", {hc, ha, ht, hovf}, 0);
    check_val("reset_hpos", oh, 0);
    check_val("reset_zoom", zm, 0);
    rst = 0;
    idle(2);

    pixel(400, 240); drain();

    coef(1, 1); do_commit(); frame();
    pixel(410, 230); pixel(410, 228); drain();

    coef(1, 5); do_commit();
    pixel(410, 230); drain();
    frame(); pixel(410, 230); drain();

    zoomp(1, 0); zoomp(1, 0); frame(); idle(1);
    check_val("zoom_after_2_in", zm, 2);
    pixel(440, 230); drain();
    repeat (3) zoomp(1, 0);
    frame(); idle(1);
    check_val("zoom_saturate_max", zm, 3);
    pixel(479, 230); pixel(392, 200); drain();
    repeat (3) zoomp(0, 1);
    frame(); idle(1);
    check_val("zoom_back_to_0", zm, 0);
    zoomp(0, 1); frame(); idle(1);
    check_val("zoom_saturate_min", zm, 0);
    zoomp(1, 1); frame(); idle(1);
    check_val("zoom_in_out_cancel", zm, 0);

    coef(4, 65535); do_commit(); frame();
    pixel(1199, 240); pixel(401, 240); drain();

    pan(1, 1, 0, 0); frame();
    pixel(400, 240); drain();
    repeat (3) pan(1, 0, 0, 0);
    frame();
    pixel(430, 240); pixel(400, 240); drain();
    pan(0, 0, 1, 0); pan(0, 0, 1, 1); frame();
    pixel(430, 250); drain();

    for (int i = 0; i < 8; i++) pixel(420 + i, 240);
    @(posedge clk); #2;
    zero_inputs();
    rst = 1;
    #1;
    check_val("midreset_out_valid", ov, 0);
    check_val("midreset_flags", {hc, ha, ht, hovf}, 0);
    sbq.delete();
    model_reset();
    @(negedge clk); @(negedge clk);
    rst = 0;
    idle(1);
    check_val("midreset_zoom", zm, 0);
    pixel(400, 240); pixel(430, 240); drain();

    for (int f = 0; f < 30; f++) begin
      rdeg = $urandom_range(0, DEG);
      for (int k = 0; k <= DEG; k++) coef(k, (k <= rdeg) ? int'($urandom_range(0, 8)) - 4 : 0);
      if ($urandom_range(0, 3) != 0) do_commit();
      repeat ($urandom_range(0, 2)) pan($urandom_range(0, 1), $urandom_range(0, 1),
                                       $urandom_range(0, 1), $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) zoomp($urandom_range(0, 1), $urandom_range(0, 1));
      frame();
      for (int p = 0; p < 40; p++) begin
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 479);
        if ($urandom_range(0, 1) == 1) begin
          x = floor_div_pow2(h - m_sx, m_zoom);
          poly(x, pval, po);
          if (!po && (m_sy - pval) >= 0 && (m_sy - pval) <= 4095) v = m_sy - int'(pval);
        end
        if ($urandom_range(0, 3) == 0) idle(1);
        pixel(h, v);
      end
      drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
